sdr_serial_fifo: RTL and testbench

//  Parametrised successor to the SoC's CIA-style serial data port (sp_in/sp_out, cnt_in/cnt_out).

---
 rtl/sdr_serial_fifo.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_sdr_serial_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_serial_fifo.sv
// sdr_serial_fifo: full-duplex serial data port for the 6502 peripheral bus.
// It has TX/RX FIFOs, a programmable bit-rate divider in master mode and
// synchronised external-clock operation in slave mode.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cs, we, addr, din   register access (0 DATA, 1 STATUS, 2 CTRL, 3 DIV)
//   dout                registered read data
//   irq                 registered level interrupt
//   sp_in, sp_out       serial data in (async) / out
//   cnt_in, cnt_out     shift clock in (async, slave) / out (master)
//   busy                frame in progress
module sdr_serial_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              irq,
    input  logic              sp_in,
    output logic              sp_out,
    input  logic              cnt_in,
    output logic              cnt_out,
    output logic              busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_DIV    = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_DONE, S_SLV} state_t;

    state_t              state, state_d;
    logic [3:0]          ctrl;
    logic [DIV_W-1:0]    div;
    logic                rxovr, txovf;

    logic [DIV_W-1:0]    hcnt, hcnt_d;
    logic [BW-1:0]       bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0]   tx_sh, tx_sh_d, rx_sh, rx_sh_d, word_c;
    logic                sp_out_d, cnt_out_d;
    logic                tx_pop, rx_push;

    logic [1:0]          sp_sync, cnt_sync;
    logic                cnt_prev, sp_in_s, cnt_fall, cnt_rise;

    logic [DATA_W-1:0]   tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   rx_mem [FIFO_DEPTH];
    logic [AW-1:0]       tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]       tx_cnt, rx_cnt;
    logic                tx_empty, tx_full, rx_empty, rx_full;
    logic                tx_push_req, tx_push_ok, tx_pop_ok;
    logic                rx_pop_req, rx_push_ok, rx_pop_ok;
    logic                bus_wr, bus_rd, ctrl_wr, status_wr, abort;
    logic [DATA_W-1:0]   tx_head, rx_head;
    logic [6:0]          status_c;

    // Bus decode; a change of master/slave mode aborts the current frame
    assign bus_wr      = cs & we;
    assign bus_rd      = cs & ~we;
    assign tx_push_req = bus_wr & (addr == A_DATA);
    assign rx_pop_req  = bus_rd & (addr == A_DATA);
    assign ctrl_wr     = bus_wr & (addr == A_CTRL);
    assign status_wr   = bus_wr & (addr == A_STATUS);
    assign abort       = ctrl_wr & (din[0] != ctrl[0]);

    // 2-FF synchronisers and edge detect on the synchronised shift clock
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_sync  <= 2'b11;
            cnt_sync <= 2'b11;
            cnt_prev <= 1'b1;
        end else begin
            sp_sync  <= {sp_sync[0], sp_in};
            cnt_sync <= {cnt_sync[0], cnt_in};
            cnt_prev <= cnt_sync[1];
        end
    end
    assign sp_in_s  = sp_sync[1];
    assign cnt_fall = cnt_prev & ~cnt_sync[1];
    assign cnt_rise = ~cnt_prev & cnt_sync[1];

    // FIFO status and push/pop qualification (push on full succeeds with a pop)
    assign tx_empty   = (tx_cnt == '0);
    assign tx_full    = (tx_cnt == FULL_CNT);
    assign rx_empty   = (rx_cnt == '0);
    assign rx_full    = (rx_cnt == FULL_CNT);
    assign tx_head    = tx_mem[tx_rp];
    assign rx_head    = rx_mem[rx_rp];
    assign tx_pop_ok  = tx_pop & ~tx_empty;
    assign tx_push_ok = tx_push_req & (~tx_full | tx_pop_ok);
    assign rx_pop_ok  = rx_pop_req & ~rx_empty;
    assign rx_push_ok = rx_push & (~rx_full | rx_pop_ok);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp] <= din;
        if (rx_push_ok) rx_mem[rx_wp] <= rx_sh_d;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push_ok) tx_wp <= tx_wp + AW'(1);
            if (tx_pop_ok)  tx_rp <= tx_rp + AW'(1);
            if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
            if (rx_pop_ok)  rx_rp <= rx_rp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push_ok) - CW'(tx_pop_ok);
            rx_cnt <= rx_cnt + CW'(rx_push_ok) - CW'(rx_pop_ok);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        if (!tx_empty) state_d = S_LOW;
                    end else if (cnt_fall) begin
                        state_d = S_SLV;
                    end
                end
                S_LOW:  if (hcnt == '0) state_d = S_HIGH;
                S_HIGH: if (hcnt == '0) state_d = (bit_cnt == LAST_BIT) ? S_DONE : S_LOW;
                S_DONE: state_d = S_IDLE;
                S_SLV:  if (cnt_rise && (bit_cnt == LAST_BIT)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: next values of the shift datapath and serial pins.
    // Master samples sp_in at the end of the high phase: the 2-FF synchroniser
    // delay makes this the value present around the rising cnt edge.
    always_comb begin
        hcnt_d    = hcnt;
        bit_cnt_d = bit_cnt;
        tx_sh_d   = tx_sh;
        rx_sh_d   = rx_sh;
        sp_out_d  = sp_out;
        cnt_out_d = cnt_out;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        word_c    = tx_empty ? '1 : tx_head;
        if (abort) begin
            hcnt_d    = '0;
            bit_cnt_d = '0;
            sp_out_d  = 1'b1;
            cnt_out_d = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    sp_out_d  = 1'b1;
                    cnt_out_d = 1'b1;
                    bit_cnt_d = '0;
                    if (ctrl[0] && !tx_empty) begin
                        tx_pop    = 1'b1;
                        sp_out_d  = word_c[DATA_W-1];
                        tx_sh_d   = {word_c[DATA_W-2:0], 1'b0};
                        cnt_out_d = 1'b0;
                        hcnt_d    = div;
                    end else if (!ctrl[0] && cnt_fall) begin
                        // an empty TX sends all ones without flagging
                        tx_pop   = ~tx_empty;
                        sp_out_d = word_c[DATA_W-1];
                        tx_sh_d  = {word_c[DATA_W-2:0], 1'b0};
                    end
                end
                S_LOW: begin
                    if (hcnt == '0) begin
                        cnt_out_d = 1'b1;
                        hcnt_d    = div;
                    end else begin
                        hcnt_d = hcnt - DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (hcnt == '0) begin
                        rx_sh_d   = {rx_sh[DATA_W-2:0], sp_in_s};
                        bit_cnt_d = bit_cnt + BW'(1);
                        if (bit_cnt != LAST_BIT) begin
                            cnt_out_d = 1'b0;
                            sp_out_d  = tx_sh[DATA_W-1];
                            tx_sh_d   = {tx_sh[DATA_W-2:0], 1'b0};
                            hcnt_d    = div;
                        end
                    end else begin
                        hcnt_d = hcnt - DIV_W'(1);
                    end
                end
                S_DONE: begin
                    rx_push   = 1'b1;
                    sp_out_d  = 1'b1;
                    cnt_out_d = 1'b1;
                    bit_cnt_d = '0;
                end
                S_SLV: begin
                    cnt_out_d = 1'b1;
                    if (cnt_fall) begin
                        sp_out_d = tx_sh[DATA_W-1];
                        tx_sh_d  = {tx_sh[DATA_W-2:0], 1'b0};
                    end
                    if (cnt_rise) begin
                        rx_sh_d   = {rx_sh[DATA_W-2:0], sp_in_s};
                        bit_cnt_d = bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            rx_push   = 1'b1;
                            sp_out_d  = 1'b1;
                            bit_cnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shift datapath and serial output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt    <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sp_out  <= 1'b1;
            cnt_out <= 1'b1;
            busy    <= 1'b0;
        end else begin
            hcnt    <= hcnt_d;
            bit_cnt <= bit_cnt_d;
            tx_sh   <= tx_sh_d;
            rx_sh   <= rx_sh_d;
            sp_out  <= sp_out_d;
            cnt_out <= cnt_out_d;
            busy    <= (state_d != S_IDLE);
        end
    end

    assign status_c = {busy, txovf, rxovr, tx_full, tx_empty, rx_full, ~rx_empty};

    // Control registers, sticky flags (set beats clear), read data and irq
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl  <= '0;
            div   <= '0;
            rxovr <= 1'b0;
            txovf <= 1'b0;
            dout  <= '0;
            irq   <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= din[3:0];
            if (bus_wr && (addr == A_DIV)) div <= DIV_W'(din);
            if (status_wr && din[4]) rxovr <= 1'b0;
            if (status_wr && din[5]) txovf <= 1'b0;
            if (rx_push && !rx_push_ok) rxovr <= 1'b1;
            if (tx_push_req && !tx_push_ok) txovf <= 1'b1;
            if (bus_rd) begin
                case (addr)
                    A_DATA:   dout <= rx_empty ? '0 : rx_head;
                    A_STATUS: dout <= DATA_W'(status_c);
                    A_CTRL:   dout <= DATA_W'(ctrl);
                    default:  dout <= DATA_W'(div);
                endcase
            end
            irq <= (ctrl[1] & ~rx_empty) | (ctrl[2] & tx_empty) | (ctrl[3] & (rxovr | txovf));
        end
    end

endmodule

// File: tb/tb_sdr_serial_fifo.sv
// Directed bench for sdr_serial_fifo (DATA_W=8, FIFO_DEPTH=4, DIV_W=8).
module tb_sdr_serial_fifo;
    logic       clk = 1'b0;
    logic       reset, cs, we, irq, sp_in, sp_out, cnt_in, cnt_out, busy;
    logic [1:0] addr;
    logic [7:0] din, dout;
    logic       loop_en, sp_drv;

    int n_cmp = 0;
    int n_bad = 0;

    logic tr_cnt  [0:199];
    logic tr_sp   [0:199];
    logic tr_busy [0:199];

    typedef struct {
        logic       wr;
        logic [1:0] a;
        logic [7:0] wd;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vt [12];

    assign sp_in = loop_en ? sp_out : sp_drv;
    always #5 clk = ~clk;

    sdr_serial_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .irq(irq), .sp_in(sp_in), .sp_out(sp_out),
        .cnt_in(cnt_in), .cnt_out(cnt_out), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_cnt[i]  = cnt_out;
            tr_sp[i]   = sp_out;
            tr_busy[i] = busy;
            @(negedge clk);
        end
    endtask

    // cnt_out run lengths and the sp_out bit present at each falling edge
    task automatic analyze(input int n, output int pulses, output int lo_bad,
                           output int hi2, output int hi4, output int hi_bad,
                           output logic [31:0] bits);
        int run;
        pulses = 0; lo_bad = 0; hi2 = 0; hi4 = 0; hi_bad = 0; bits = '0; run = 1;
        for (int i = 1; i < n; i++) begin
            if (tr_cnt[i] == tr_cnt[i-1]) begin
                run++;
            end else begin
                if (tr_cnt[i-1] == 1'b0) begin
                    if (run != 2) lo_bad++;
                end else if (pulses > 0) begin
                    if (run == 2) hi2++;
                    else if (run == 4) hi4++;
                    else hi_bad++;
                end
                if (tr_cnt[i] == 1'b0) begin
                    pulses++;
                    bits = {bits[30:0], tr_sp[i]};
                end
                run = 1;
            end
        end
    endtask

    task automatic busy_gaps(input int n, output int gaps, output int bad);
        int  z;
        logic seen;
        gaps = 0; bad = 0; z = 0; seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tr_busy[i]) begin
                if (seen && z > 0) begin
                    gaps++;
                    if (z != 1) bad++;
                end
                seen = 1'b1;
                z = 0;
            end else begin
                z++;
            end
        end
    endtask

    // Slave frame: 10 clk per half; sp_out captured at each cnt_in rise.
    // Returns right at the last rise.
    task automatic slave_frame(input logic [7:0] pat, output logic [7:0] cap);
        cap = '0;
        for (int i = 7; i >= 0; i--) begin
            cnt_in = 1'b0;
            sp_drv = pat[i];
            repeat (10) @(negedge clk);
            cap = {cap[6:0], sp_out};
            cnt_in = 1'b1;
            if (i != 0) repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, lo_bad, hi2, hi4, hi_bad, gaps, gbad;
        logic [31:0] bits;
        logic [7:0]  cap;

        vt[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, "rst_data"};
        vt[1]  = '{1'b0, 2'd1, 8'h00, 8'h04, "rst_status"};
        vt[2]  = '{1'b0, 2'd2, 8'h00, 8'h00, "rst_ctrl"};
        vt[3]  = '{1'b0, 2'd3, 8'h00, 8'h00, "rst_div"};
        vt[4]  = '{1'b1, 2'd3, 8'h5A, 8'h00, "wr_div"};
        vt[5]  = '{1'b0, 2'd3, 8'h00, 8'h5A, "div_rb"};
        vt[6]  = '{1'b1, 2'd2, 8'h0E, 8'h00, "wr_ctrl"};
        vt[7]  = '{1'b0, 2'd2, 8'h00, 8'h0E, "ctrl_rb"};
        vt[8]  = '{1'b1, 2'd1, 8'hFF, 8'h00, "wr_status"};
        vt[9]  = '{1'b0, 2'd1, 8'h00, 8'h04, "status_ignored_bits"};
        vt[10] = '{1'b1, 2'd2, 8'h00, 8'h00, "wr_ctrl0"};
        vt[11] = '{1'b0, 2'd2, 8'h00, 8'h00, "ctrl0_rb"};

        reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
        cnt_in = 1'b1; sp_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_sp_out",  32'(sp_out),  32'd1);
        check("rst_cnt_out", 32'(cnt_out), 32'd1);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_irq",     32'(irq),     32'd0);
        check("rst_dout",    32'(dout),    32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) bus_write(vt[i].a, vt[i].wd);
            else          read_check(vt[i].name, vt[i].a, vt[i].exp);
        end

        // ie_tx with empty TX: irq one cycle after CTRL lands
        bus_write(2'd2, 8'h04);
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_tx_empty", 32'(irq), 32'd1);
        bus_write(2'd2, 8'h00);
        @(negedge clk);
        check("irq_off", 32'(irq), 32'd0);

        // Master loopback, DIV=1, single word 0xA5
        bus_write(2'd3, 8'h01);
        bus_write(2'd2, 8'h01);
        loop_en = 1'b1;
        bus_write(2'd0, 8'hA5);
        capture(50);
        analyze(50, pulses, lo_bad, hi2, hi4, hi_bad, bits);
        check("a5_pulses",  32'(pulses), 32'd8);
        check("a5_low_len", 32'(lo_bad), 32'd0);
        check("a5_high2",   32'(hi2),    32'd7);
        check("a5_hi_other", 32'(hi4 + hi_bad), 32'd0);
        check("a5_sp_bits", bits, 32'h0000_00A5);
        check("a5_sp_idle", 32'(sp_out), 32'd1);
        check("a5_busy_end", 32'(busy), 32'd0);
        read_check("a5_status", 2'd1, 8'h05);
        read_check("a5_data", 2'd0, 8'hA5);
        read_check("a5_empty_read", 2'd0, 8'h00);

        // Overfill TX while serial idle (slave, no cnt_in activity)
        bus_write(2'd2, 8'h00);
        bus_write(2'd0, 8'h11);
        bus_write(2'd0, 8'h22);
        bus_write(2'd0, 8'h33);
        bus_write(2'd0, 8'h44);
        bus_write(2'd0, 8'h55);
        read_check("txovf_status", 2'd1, 8'h28);
        bus_write(2'd1, 8'h20);
        read_check("txovf_cleared", 2'd1, 8'h08);
        bus_write(2'd2, 8'h01);
        capture(150);
        analyze(150, pulses, lo_bad, hi2, hi4, hi_bad, bits);
        busy_gaps(150, gaps, gbad);
        check("b2b_pulses",  32'(pulses), 32'd32);
        check("b2b_low_len", 32'(lo_bad), 32'd0);
        check("b2b_high2",   32'(hi2),    32'd28);
        check("b2b_high4",   32'(hi4),    32'd3);
        check("b2b_hi_bad",  32'(hi_bad), 32'd0);
        check("b2b_sp_bits", bits, 32'h1122_3344);
        check("b2b_gaps",    32'(gaps),   32'd3);
        check("b2b_gap_len", 32'(gbad),   32'd0);
        read_check("b2b_status", 2'd1, 8'h07);
        read_check("b2b_w0", 2'd0, 8'h11);
        read_check("b2b_w1", 2'd0, 8'h22);
        read_check("b2b_w2", 2'd0, 8'h33);
        read_check("b2b_w3", 2'd0, 8'h44);
        read_check("b2b_drained", 2'd0, 8'h00);

        // Slave mode, TX holds 0x81, sp_in pattern 0x3C
        loop_en = 1'b0;
        bus_write(2'd2, 8'h00);
        bus_write(2'd0, 8'h81);
        slave_frame(8'h3C, cap);
        repeat (10) @(negedge clk);
        check("slv_sp_out", 32'(cap), 32'h81);
        check("slv_busy",   32'(busy), 32'd0);
        check("slv_sp_idle", 32'(sp_out), 32'd1);
        check("slv_cnt_out", 32'(cnt_out), 32'd1);
        read_check("slv_rx", 2'd0, 8'h3C);
        slave_frame(8'hC3, cap);
        repeat (10) @(negedge clk);
        check("slv_empty_tx_ones", 32'(cap), 32'hFF);
        read_check("slv_noflag_status", 2'd1, 8'h05);
        read_check("slv_rx2", 2'd0, 8'hC3);

        // RX overrun with ie_err only
        bus_write(2'd2, 8'h08);
        for (int f = 1; f <= 4; f++) begin
            slave_frame(8'(f), cap);
            repeat (10) @(negedge clk);
        end
        read_check("rx_full_status", 2'd1, 8'h07);
        check("irq_before_ovr", 32'(irq), 32'd0);
        slave_frame(8'h05, cap);
        repeat (3) @(negedge clk);
        check("irq_at_ovr_set", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_after_ovr", 32'(irq), 32'd1);
        read_check("rxovr_status", 2'd1, 8'h17);
        bus_write(2'd1, 8'h10);
        check("irq_clear_lag", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        read_check("rxovr_cleared", 2'd1, 8'h07);
        read_check("ovr_w0", 2'd0, 8'h01);
        read_check("ovr_w1", 2'd0, 8'h02);
        read_check("ovr_w2", 2'd0, 8'h03);
        read_check("ovr_w3", 2'd0, 8'h04);
        read_check("ovr_drained", 2'd0, 8'h00);

        // Mode toggle during bit 3 of a master frame
        bus_write(2'd2, 8'h01);
        loop_en = 1'b1;
        bus_write(2'd0, 8'h5A);
        repeat (14) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        bus_write(2'd2, 8'h00);
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_cnt_out", 32'(cnt_out), 32'd1);
        check("abort_sp_out",  32'(sp_out),  32'd1);
        repeat (40) @(negedge clk);
        read_check("abort_no_push", 2'd1, 8'h04);

        // Reset mid-frame
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'h3C);
        repeat (10) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstm_busy",    32'(busy),    32'd0);
        check("rstm_cnt_out", 32'(cnt_out), 32'd1);
        check("rstm_sp_out",  32'(sp_out),  32'd1);
        repeat (40) @(negedge clk);
        read_check("rstm_status", 2'd1, 8'h04);
        read_check("rstm_ctrl",   2'd2, 8'h00);
        read_check("rstm_div",    2'd3, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
